prog_loader: RTL and testbench
==============================

# prog_loader

Program loader that sits directly upstream of the 8-bit `cpu`. It accepts a byte stream over a valid/ready handshake and writes the program image into the CPU's 256×8 RAM. It holds the CPU in reset while loading and issues a one-cycle run pulse once the image is complete and verified. The CPU's stage sequencer only starts after this block releases it.

## Interface
Parameters:
- `BASE_ADDR`, default 8'h00: RAM address of the first program byte.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `start`  input  1  begin a load; sampled in IDLE, DONE and ERR only.
- `rx_data`  input  8  incoming byte.
- `rx_valid`  input  1  `rx_data` is valid.
- `rx_ready`  output  1  block accepts a byte this cycle.
- `ram_addr`  output  8  RAM write address.
- `ram_data`  output  8  RAM write data.
- `ram_wren`  output  1  RAM write enable.
- `cpu_hold`  output  1  drives the CPU reset; 1 = CPU held.
- `cpu_run`  output  1  one-cycle run pulse to the CPU.
- `busy`  output  1  load in progress.
- `done`  output  1  last load succeeded.
- `err`  output  1  last load failed the checksum.

## Operation
- Frame format: a LEN byte, then N data bytes, then (if configured) a SUM byte. LEN=0 means N=256.
- States: IDLE, LEN, DATA, SUM, RUN, DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR: `start`=1 → LEN. Entering LEN clears `done`/`err`, the byte counter and the running sum.
  - LEN: on a handshake, latch N → DATA.
  - DATA: on each handshake, write the byte and add it to the running sum (mod 256). After the Nth byte → SUM (checksum build) or RUN.
  - SUM: on a handshake, compare the received byte to the running sum. Equal → RUN; else → ERR.
  - RUN: one cycle → DONE.
- Handshake: a byte transfers on a rising edge where `rx_valid`=1 and `rx_ready`=1.
  - `rx_ready`=1 in LEN, DATA and SUM only; 0 in all other states.
  - `rx_valid` without `rx_ready` is ignored; no byte is consumed.
- Address rule: the i-th data byte (i = 0..N-1) goes to (`BASE_ADDR` + i) mod 256. Wrap-around past 8'hFF is legal.
- `cpu_hold`:
  - 1 from reset and throughout LEN/DATA/SUM/RUN/ERR.
  - Drops to 0 in the cycle after RUN (DONE).
  - Reasserts immediately when `start` re-enters LEN.
- `cpu_run`: 1 only in the RUN cycle. `cpu_hold` is still 1 in that cycle, so the CPU sees run coincident with release.
- `busy`: 1 in LEN, DATA, SUM, RUN.
- `start` while `busy` is ignored.
- ERR is sticky until the next `start`. RAM contents written before the error are not scrubbed.
- Reset mid-load: all state returns to IDLE with reset values. Partially written RAM is left as is.

## Timing
- Reset values:
  - state IDLE.
  - `rx_ready`=0, `ram_addr`=`BASE_ADDR`, `ram_data`=0, `ram_wren`=0.
  - `cpu_hold`=1, `cpu_run`=0, `busy`=0, `done`=0, `err`=0.
- RAM write is registered. A handshake on edge k produces `ram_wren`=1 with `ram_addr`/`ram_data` valid for exactly the cycle after edge k. RAM captures the write on edge k+1.
- Back-to-back bytes (`rx_valid` held high) give one byte and one write per cycle with no bubbles.
- The final RAM write is issued no later than the RUN cycle. With checksum on, the SUM handshake occurs at least one cycle after the last data handshake, so all writes complete before `cpu_run`.
- Latency from the last accepted byte to `cpu_run` (no mismatch): 1 cycle.
- `start` → `rx_ready`=1: 1 cycle (the LEN state is entered on the edge that samples `start`).

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - SUM state is present; the frame is LEN + N + SUM.
  - A mismatch goes to ERR and the CPU stays held.
- `LOADER_CHECKSUM_EN` undefined:
  - No SUM state and no sum register; DATA goes straight to RUN after the Nth byte.
  - `err` is tied to 0.

## Test plan
- Reset held low mid-DATA, then released → all outputs at their reset values. IDLE: `cpu_hold`=1, `rx_ready`=0. No `ram_wren` after release.
- `BASE_ADDR`=0, checksum on, stream 03,11,22,33,66 with `rx_valid` continuous → writes [00]=11, [01]=22, [02]=33 on consecutive cycles. One-cycle `cpu_run`, then `done`=1, `cpu_hold`=0.
- Same frame with SUM=67 → state ERR, `err`=1, `cpu_hold`=1, no `cpu_run`. Then `start` plus the correct frame → `done`=1, `err`=0.
- `BASE_ADDR`=FE, LEN=03, data AA,BB,CC → writes [FE]=AA, [FF]=BB, [00]=CC (wrap).
- `rx_valid` toggled 1-0-1 with gaps, and `start` pulsed during DATA → only handshaked bytes are written in order. `start` has no effect; the byte count is exact.
- LEN=00 → exactly 256 writes covering every address once, then SUM/RUN.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: receives a LEN/data[/SUM] byte frame and writes it into CPU RAM at BASE_ADDR.
// Define LOADER_CHECKSUM_EN to enable the trailing checksum byte and the error state.
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_wren,
  output logic       cpu_hold,
  output logic       cpu_run,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
`ifdef LOADER_CHECKSUM_EN
    StSum,
`endif
    StRun,
    StDone,
    StErr
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] len_q, len_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic       ram_wren_q, ram_wren_d;
  logic       hs;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  assign hs = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 9'd0;
      len_q      <= 9'd0;
      ram_addr_q <= BASE_ADDR;
      ram_data_q <= 8'h00;
      ram_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          cnt_d   = 9'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      StLen: begin
        if (hs) begin
          // LEN of zero encodes a full 256-byte image
          len_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = StData;
        end
      end
      StData: begin
        if (hs) begin
          ram_addr_d = BASE_ADDR + cnt_q[7:0];
          ram_data_d = rx_data;
          ram_wren_d = 1'b1;
          cnt_d      = cnt_q + 9'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_data;
          if (cnt_q + 9'd1 == len_q) state_d = StSum;
`else
          if (cnt_q + 9'd1 == len_q) state_d = StRun;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StSum: begin
        if (hs) begin
          state_d = (rx_data == sum_q) ? StRun : StErr;
        end
      end
`endif
      StRun: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    cpu_hold = 1'b1;
    cpu_run  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      StLen, StData: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StSum: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      StErr: begin
        err = 1'b1;
      end
`endif
      StRun: begin
        // run coincides with the last held cycle so the CPU starts cleanly on release
        cpu_run = 1'b1;
        busy    = 1'b1;
      end
      StDone: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
      end
    endcase
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 00 and FE) share one byte stream.
module tb_prog_loader;

  typedef logic [7:0] byte_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       rdy0, wren0, hold0, run0, busy0, done0, err0;
  logic [7:0] addr0, data0;
  logic       rdy1, wren1, hold1, run1, busy1, done1, err1;
  logic [7:0] addr1, data1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int runs0 = 0;
  int run_cyc = -1;
  int last_hs = -1;
  wr_t q0[$];
  wr_t q1[$];

  prog_loader #(.BASE_ADDR(8'h00)) u0 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .ram_addr(addr0), .ram_data(data0), .ram_wren(wren0),
    .cpu_hold(hold0), .cpu_run(run0), .busy(busy0), .done(done0), .err(err0)
  );

  prog_loader #(.BASE_ADDR(8'hFE)) u1 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .ram_addr(addr1), .ram_data(data1), .ram_wren(wren1),
    .cpu_hold(hold1), .cpu_run(run1), .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/run monitor sampled mid-cycle
  always @(negedge clk) begin
    wr_t w;
    if (wren0) begin
      w.a = addr0; w.d = data0; w.c = cyc;
      q0.push_back(w);
    end
    if (wren1) begin
      w.a = addr1; w.d = data1; w.c = cyc;
      q1.push_back(w);
    end
    if (run0) begin
      runs0 = runs0 + 1;
      run_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    q0.delete();
    q1.delete();
    runs0 = 0;
    run_cyc = -1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input byte_t b);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 20; t++) begin
      if (rdy0) begin
        step();
        last_hs = cyc;
        return;
      end
      step();
    end
    rx_valid = 1'b0;
    errors++;
    checks++;
    $display("FAIL handshake_timeout: byte %h never accepted", b);
  endtask

  task automatic send_frame(input byte_t f[$], input int gap, input bit pulse_start);
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i]);
      if (gap > 0 && i < f.size() - 1) begin
        rx_valid = 1'b0;
        rx_data  = 8'h5C;
        for (int g = 0; g < gap; g++) begin
          if (pulse_start && i == 2) start = 1'b1;
          step();
          start = 1'b0;
        end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic make_frame(input byte_t len, input byte_t d[$], input bit bad_sum,
                            output byte_t f[$]);
    byte_t s;
    s = 8'h00;
    f.delete();
    f.push_back(len);
    foreach (d[i]) begin
      f.push_back(d[i]);
      s = s + d[i];
    end
`ifdef LOADER_CHECKSUM_EN
    f.push_back(bad_sum ? s + 8'h01 : s);
`else
    if (bad_sum) s = s;
`endif
  endtask

  task automatic test_reset();
    logic [22:0] got, want;
    byte_t f[$];
    repeat (2) @(negedge clk);
    #1;
    want = {1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    got  = {rdy0, addr0, data0, wren0, hold0, run0, busy0, done0, err0};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_u0: got %h want %h", got, want);
    end
    want = {1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    got  = {rdy1, addr1, data1, wren1, hold1, run1, busy1, done1, err1};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_u1: got %h want %h", got, want);
    end
    rst = 1'b1;
    step();
    do_start();
    f = '{8'h05, 8'h01, 8'h02};
    send_frame(f, 0, 1'b0);
    rst = 1'b0;
    #1;
    want = {1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    got  = {rdy0, addr0, data0, wren0, hold0, run0, busy0, done0, err0};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_mid_data: got %h want %h", got, want);
    end
    step();
    rst = 1'b1;
    clear_log();
    repeat (4) step();
    checks++;
    if (q0.size() + q1.size() !== 0) begin
      errors++; $display("FAIL reset_no_wren: got %0d writes want 0", q0.size() + q1.size());
    end
    checks++;
    if ({hold0, rdy0, busy0} !== 3'b100) begin
      errors++; $display("FAIL reset_idle: got hold/ready/busy %b want 100", {hold0, rdy0, busy0});
    end
  endtask

  task automatic test_basic();
    byte_t f[$];
    byte_t d[$];
    byte_t exp_d[3];
    clear_log();
    do_start();
    checks++;
    if ({rdy0, busy0, hold0} !== 3'b111) begin
      errors++; $display("FAIL start_latency: got ready/busy/hold %b want 111", {rdy0, busy0, hold0});
    end
    d = '{8'h11, 8'h22, 8'h33};
    make_frame(8'h03, d, 1'b0, f);
    send_frame(f, 0, 1'b0);
    checks++;
    if ({run0, hold0} !== 2'b11) begin
      errors++; $display("FAIL run_cycle: got run/hold %b want 11", {run0, hold0});
    end
    checks++;
    if (run_cyc !== last_hs) begin
      errors++; $display("FAIL run_latency: got cycle %0d want %0d", run_cyc, last_hs);
    end
    step();
    checks++;
    if ({done0, hold0, busy0, err0, run0} !== 5'b10000) begin
      errors++;
      $display("FAIL done_state: got done/hold/busy/err/run %b want 10000",
               {done0, hold0, busy0, err0, run0});
    end
    checks++;
    if (q0.size() !== 3 || runs0 !== 1) begin
      errors++; $display("FAIL basic_counts: got %0d writes %0d runs want 3 and 1", q0.size(), runs0);
    end else begin
      exp_d = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q0[i].a !== i[7:0] || q0[i].d !== exp_d[i] || q0[i].c !== q0[0].c + i) begin
          errors++;
          $display("FAIL basic_write%0d: got [%h]=%h at +%0d want [%h]=%h at +%0d",
                   i, q0[i].a, q0[i].d, q0[i].c - q0[0].c, i[7:0], exp_d[i], i);
        end
      end
    end
    step();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_err();
    byte_t f[$];
    byte_t d[$];
    clear_log();
    do_start();
    d = '{8'h11, 8'h22, 8'h33};
    make_frame(8'h03, d, 1'b1, f);
    send_frame(f, 0, 1'b0);
    step();
    checks++;
    if ({err0, hold0, done0, busy0, rdy0} !== 5'b11000) begin
      errors++;
      $display("FAIL err_state: got err/hold/done/busy/ready %b want 11000",
               {err0, hold0, done0, busy0, rdy0});
    end
    checks++;
    if (runs0 !== 0) begin
      errors++; $display("FAIL err_no_run: got %0d runs want 0", runs0);
    end
    checks++;
    if (q0.size() !== 3) begin
      errors++; $display("FAIL err_writes_kept: got %0d writes want 3", q0.size());
    end
    do_start();
    checks++;
    if ({err0, busy0, hold0} !== 3'b011) begin
      errors++; $display("FAIL err_cleared: got err/busy/hold %b want 011", {err0, busy0, hold0});
    end
    make_frame(8'h03, d, 1'b0, f);
    send_frame(f, 0, 1'b0);
    step();
    checks++;
    if ({done0, err0, hold0} !== 3'b100 || runs0 !== 1) begin
      errors++;
      $display("FAIL err_recover: got done/err/hold %b runs %0d want 100 runs 1",
               {done0, err0, hold0}, runs0);
    end
    step();
  endtask
`else
  task automatic test_no_checksum();
    byte_t f[$];
    byte_t d[$];
    clear_log();
    do_start();
    d = '{8'h11, 8'h22, 8'h33};
    make_frame(8'h03, d, 1'b1, f);
    send_frame(f, 0, 1'b0);
    checks++;
    if (run0 !== 1'b1) begin
      errors++; $display("FAIL nosum_run: got run %b want 1", run0);
    end
    step();
    checks++;
    if ({done0, err0, rdy0} !== 3'b100) begin
      errors++; $display("FAIL nosum_done: got done/err/ready %b want 100", {done0, err0, rdy0});
    end
    step();
  endtask
`endif

  task automatic test_wrap();
    byte_t f[$];
    byte_t d[$];
    clear_log();
    do_start();
    d = '{8'hAA, 8'hBB, 8'hCC};
    make_frame(8'h03, d, 1'b0, f);
    send_frame(f, 0, 1'b0);
    step();
    checks++;
    if (q1.size() !== 3) begin
      errors++; $display("FAIL wrap_count: got %0d writes want 3", q1.size());
    end else begin
      checks++;
      if ({q1[0].a, q1[0].d, q1[1].a, q1[1].d, q1[2].a, q1[2].d} !== 48'hFEAA_FFBB_00CC) begin
        errors++;
        $display("FAIL wrap_writes: got %h%h_%h%h_%h%h want FEAA_FFBB_00CC",
                 q1[0].a, q1[0].d, q1[1].a, q1[1].d, q1[2].a, q1[2].d);
      end
    end
    checks++;
    if ({done1, hold1} !== 2'b10) begin
      errors++; $display("FAIL wrap_done: got done/hold %b want 10", {done1, hold1});
    end
    step();
  endtask

  task automatic test_gaps();
    byte_t f[$];
    byte_t d[$];
    byte_t exp_d[4];
    clear_log();
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (3) step();
    checks++;
    if (q0.size() !== 0 || rdy0 !== 1'b0) begin
      errors++; $display("FAIL valid_ignored: got %0d writes ready %b want 0 0", q0.size(), rdy0);
    end
    rx_valid = 1'b0;
    do_start();
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    make_frame(8'h04, d, 1'b0, f);
    send_frame(f, 2, 1'b1);
    step();
    checks++;
    if (q0.size() !== 4 || runs0 !== 1 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL gaps_count: got %0d writes %0d runs done %b want 4 1 1",
               q0.size(), runs0, done0);
    end else begin
      exp_d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q0[i].a !== i[7:0] || q0[i].d !== exp_d[i]) begin
          errors++;
          $display("FAIL gaps_write%0d: got [%h]=%h want [%h]=%h",
                   i, q0[i].a, q0[i].d, i[7:0], exp_d[i]);
        end
      end
      checks++;
      if (q0[1].c - q0[0].c !== 3) begin
        errors++; $display("FAIL gaps_spacing: got %0d cycles want 3", q0[1].c - q0[0].c);
      end
    end
    step();
  endtask

  task automatic test_len0();
    byte_t f[$];
    byte_t d[$];
    int bad;
    clear_log();
    for (int i = 0; i < 256; i++) d.push_back(i[7:0] ^ 8'h5A);
    do_start();
    make_frame(8'h00, d, 1'b0, f);
    send_frame(f, 0, 1'b0);
    checks++;
    if (run0 !== 1'b1) begin
      errors++; $display("FAIL len0_run: got run %b want 1", run0);
    end
    step();
    checks++;
    if (q0.size() !== 256 || done0 !== 1'b1) begin
      errors++; $display("FAIL len0_count: got %0d writes done %b want 256 1", q0.size(), done0);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (q0[i].a !== i[7:0] || q0[i].d !== (i[7:0] ^ 8'h5A)) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL len0_writes: got %0d wrong writes want 0", bad);
      end
    end
    checks++;
    if (q1.size() !== 256 || q1[0].a !== 8'hFE || q1[255].a !== 8'hFD) begin
      errors++; $display("FAIL len0_wrap_u1: got %0d writes want 256 from FE to FD", q1.size());
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_err();
`else
    test_no_checksum();
`endif
    test_wrap();
    test_gaps();
    test_len0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
